// File: rtl/led_flash_multi.sv
`default_nettype none
// ============================================================================
// Module   : led_flash_multi
// Purpose  : Multi-channel LED stretcher / blinker. Each channel lights while
//            its activity input is high, then holds lit for 'period' clocks
//            after the input drops. The LED can optionally blink, or be
//            forced lit or dark per channel.
// Ports    : clock      - system clock, rising edge
//            reset_n    - asynchronous active-low reset
//            signal     - per-channel activity input [CHANNELS]
//            mode       - per-channel mode, 2 bits each [2*CHANNELS]
//                         00 steady, 01 blink, 10 forced lit, 11 forced dark
//            period     - hold time after signal falls (shared)
//            blink_half - blink half-period minus one (shared)
//            LED        - LED pin drive, polarity set by ACTIVE_LOW
//            busy       - channel FSM not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module led_flash_multi #(
  parameter int CHANNELS   = 4,
  parameter int CNT_WIDTH  = 25,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   signal,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CNT_WIDTH-1:0]  period,
  input  logic [CNT_WIDTH-1:0]  blink_half,
  output logic [CHANNELS-1:0]   LED,
  output logic [CHANNELS-1:0]   busy
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_active = 2'd1;
  localparam logic [1:0] c_hold   = 2'd2;

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic                 c_pol     = (ACTIVE_LOW != 0);

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [1:0]           r_state;
      logic [1:0]           w_state_nx;
      logic [CNT_WIDTH-1:0] r_hold;
      logic [CNT_WIDTH-1:0] w_hold_nx;
      logic [CNT_WIDTH-1:0] r_bcnt;
      logic [CNT_WIDTH-1:0] w_bcnt_nx;
      logic                 r_phase;
      logic                 w_phase_nx;
      logic                 w_lit_nx;
      logic                 w_sel;
      logic                 r_led;
      logic [1:0]           w_mode;

      assign w_mode = mode[2*i +: 2];

      // Next-state and counter logic. The hold compare is against the live
      // period, so shrinking period mid-hold ends the hold on the next edge
      // and the counter can never run past it.
      always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = r_hold;
        if (signal[i]) begin
          w_state_nx = c_active;
          w_hold_nx  = '0;
        end else if (r_state != c_idle) begin
          if (r_hold >= period) begin
            w_state_nx = c_idle;
            w_hold_nx  = '0;
          end else begin
            w_state_nx = c_hold;
            w_hold_nx  = r_hold + c_cnt_one;
          end
        end
      end

      // Blink phase restarts "on" only when leaving IDLE; a retrigger from
      // HOLD keeps the running phase.
      always_comb begin
        w_bcnt_nx  = r_bcnt;
        w_phase_nx = r_phase;
        if (r_state == c_idle) begin
          if (w_state_nx != c_idle) begin
            w_bcnt_nx  = '0;
            w_phase_nx = 1'b1;
          end
        end else if (r_bcnt >= blink_half) begin
          w_bcnt_nx  = '0;
          w_phase_nx = ~r_phase;
        end else begin
          w_bcnt_nx  = r_bcnt + c_cnt_one;
        end
      end

      // Output is selected from next-state values so the LED register shows
      // the state entered on the same edge (one-clock latency from signal).
      always_comb begin
        w_lit_nx = (w_state_nx != c_idle);
        case (w_mode)
          2'b00:   w_sel = w_lit_nx;
          2'b01:   w_sel = w_lit_nx & w_phase_nx;
          2'b10:   w_sel = 1'b1;
          default: w_sel = 1'b0;
        endcase
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_state <= c_idle;
          r_hold  <= '0;
          r_bcnt  <= '0;
          r_phase <= 1'b0;
          r_led   <= c_pol;
        end else begin
          r_state <= w_state_nx;
          r_hold  <= w_hold_nx;
          r_bcnt  <= w_bcnt_nx;
          r_phase <= w_phase_nx;
          r_led   <= w_sel ^ c_pol;
        end
      end

      assign LED[i]  = r_led;
      assign busy[i] = (r_state != c_idle);
    end
  endgenerate

endmodule
`default_nettype wire
